fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Instruction fetch stage with a small prefetch queue, sitting directly upstream of the decode stage register.
- Owns the PC and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions with their PC+4 and hands them to decode over a valid/ready handshake.
- Accepts a branch redirect from the resolving stage, which flushes queued and in-flight instructions.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset; bits [1:0] must be 0
QDEPTH, 4, prefetch queue entries; power of 2, minimum 2

Ports:
Clk  input  1  core clock; all state updates on rising edge
Rst  input  1  synchronous reset, active-high
ImemRdAddr  output  32  instruction memory word address, byte-addressed, bits [1:0] always 0
ImemRdEn  output  1  read request; data returns on ImemRdData in the following cycle
ImemRdData  input  32  instruction word for the request issued in the previous cycle
RedirectValid  input  1  one-cycle pulse: branch taken, restart fetch
RedirectPC  input  32  new fetch address; bits [1:0] ignored and treated as 0
InstrValid  output  1  queue head valid
InstrReady  input  1  decode accepts head this cycle
Instruction  output  32  queue head instruction word
PCPlus4  output  32  queue head fetch address + 4
Occupancy  output  $clog2(QDEPTH)+1  number of valid queue entries

Behaviour:
- Reset (Rst=1 at an edge):
  - PC <= RESET_PC; queue emptied; in-flight flag cleared.
  - Outputs after the edge: InstrValid=0, Occupancy=0, ImemRdEn=0.
  - Rst overrides RedirectValid and every other input. Reset mid-operation discards all queued and in-flight data.
- Issue rule (combinational):
  - ImemRdEn = !Rst && !RedirectValid && (Occupancy + inflight) < QDEPTH.
  - ImemRdAddr = PC.
  - On an issue edge: PC <= PC + 4 (32-bit wrap; 0xFFFFFFFC -> 0x00000000), and inflight <= 1 with its address recorded.
- Return:
  - When inflight=1 and not killed, ImemRdData plus (recorded address + 4) is pushed at the next edge.
  - inflight clears unless a new issue occurs in the same cycle; at most one request is outstanding per cycle.
- Latency:
  - Issue in cycle N, push at end of N+1, InstrValid=1 in N+2.
  - First valid instruction appears 2 cycles after the first non-reset cycle.
- Throughput: with InstrReady held high, one instruction per cycle in steady state.
- Handshake:
  - Pop occurs on an edge where InstrValid && InstrReady.
  - Instruction and PCPlus4 are stable while InstrValid=1 and InstrReady=0.
  - Push and pop in the same cycle leave Occupancy unchanged.
- Full: while Occupancy + inflight == QDEPTH, no issue occurs; the in-flight return always has a free slot (no overflow, no drop).
- Empty: InstrValid=0; Instruction and PCPlus4 are don't-care and must not be X after reset (hold last value or 0).
- Redirect (RedirectValid=1 at an edge):
  - Queue flushed to empty and PC <= {RedirectPC[31:2],2'b00}.
  - Any request in flight during the redirect cycle is killed: its data is not pushed.
  - ImemRdEn=0 during the redirect cycle.
  - The first new issue happens in the cycle after the redirect; the first redirected instruction is valid 3 cycles after the redirect edge.
- Redirect with a simultaneous pop:
  - InstrValid is forced 0 combinationally while RedirectValid=1, so no handshake completes.
  - Decode must not latch that cycle.
- Back-to-back redirects: each one restarts from its own RedirectPC; only the last one is effective.
- Pointer arithmetic: rd/wr pointers are $clog2(QDEPTH) bits and wrap naturally. The count is held separately, one bit wider.

Decomposition:
- Shared package fetch_pkg:
  - WORD_W=32, INSTR_BYTES=4.
  - NOP_INSTR=32'h00000000.
  - Word-align helper constant ALIGN_MASK=32'hFFFFFFFC.
- Sub-module fetch_queue: synchronous FIFO (width 64: instruction + PC+4) with flush, push, pop and count. Flush has priority over push; push-with-flush is dropped.
- The top-level block holds the PC, the inflight/kill logic and the issue rule.

Test Plan:
- Reset release, InstrReady=1, imem returning addr-tagged words -> InstrValid rises in the 3rd cycle with PCPlus4=0x4; subsequent PCPlus4 values 0x8, 0xC, 0x10 on consecutive cycles.
- InstrReady=0 for 10 cycles -> Occupancy saturates at 4 and ImemRdEn stays 0 once full. After release, 4 heads pop in order with no loss or duplication.
- RedirectValid with RedirectPC=0x00000043 while the queue holds 3 entries and 1 request is in flight -> Occupancy=0 next cycle; the stale word is never presented; the next issue address is 0x40; the first valid head has PCPlus4=0x44.
- RedirectValid and InstrReady both high with InstrValid pending -> InstrValid observed 0 that cycle; the old head is not counted as consumed.
- Rst asserted for 1 cycle mid-stream with a full queue -> next cycle Occupancy=0, ImemRdEn=0; fetch restarts from RESET_PC.
- RESET_PC=0xFFFFFFF8, streaming -> issue addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; the PCPlus4 sequence is 0xFFFFFFFC, 0x00000000, 0x00000004.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and queue entry type for the fetch stage
package fetch_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_W-1:0] NOP_INSTR  = 32'h00000000;
    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'hFFFFFFFC;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus4;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
        return addr + WORD_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO holding instruction + PC+4; flush beats push and pop
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !flush && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to NOP whenever the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        if (count_q == '0) begin
            head = '{instr: NOP_INSTR, pc_plus4: NOP_INSTR};
        end else begin
            head = mem_q[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - fetch stage: PC, imem issue with kill on redirect, prefetch queue to decode
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          QDEPTH   = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    output logic [31:0]             ImemRdAddr,
    output logic                    ImemRdEn,
    input  logic [31:0]             ImemRdData,
    input  logic                    RedirectValid,
    input  logic [31:0]             RedirectPC,
    output logic                    InstrValid,
    input  logic                    InstrReady,
    output logic [31:0]             Instruction,
    output logic [31:0]             PCPlus4,
    output logic [$clog2(QDEPTH):0] Occupancy
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [WORD_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] inflight_addr_q, inflight_addr_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    demand;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // Counting the outstanding request against capacity guarantees its return always has a slot.
    always_comb begin
        demand    = {1'b0, count} + (CNT_W + 1)'(inflight_q);
        issue     = !Rst && !RedirectValid && (demand < (CNT_W + 1)'(QDEPTH));
        push      = inflight_q && !RedirectValid && !Rst;
        push_data = '{instr: ImemRdData, pc_plus4: next_word_addr(inflight_addr_q)};

        pc_d            = pc_q;
        inflight_d      = issue;
        inflight_addr_d = inflight_addr_q;
        if (RedirectValid) begin
            pc_d = RedirectPC & ALIGN_MASK;
        end else if (issue) begin
            pc_d = next_word_addr(pc_q);
        end
        if (issue) begin
            inflight_addr_d = pc_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q            <= RESET_PC & ALIGN_MASK;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    // The head is hidden during a redirect so decode never completes a handshake on a flushed entry.
    always_comb begin
        InstrValid = (count != '0) && !RedirectValid;
        pop        = InstrValid && InstrReady;
    end

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk      (Clk),
        .rst      (Rst),
        .flush    (RedirectValid),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    assign ImemRdAddr  = pc_q;
    assign ImemRdEn    = issue;
    assign Instruction = head.instr;
    assign PCPlus4     = head.pc_plus4;
    assign Occupancy   = count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed bench for fetch_prefetch_unit (two RESET_PC configurations)
module tb_fetch_prefetch_unit;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst;
    logic        RedirectValid;
    logic [31:0] RedirectPC;
    logic        InstrReady;
    logic [31:0] ImemRdData = 32'h0;
    logic [31:0] ImemRdAddr;
    logic        ImemRdEn;
    logic        InstrValid;
    logic [31:0] Instruction;
    logic [31:0] PCPlus4;
    logic [2:0]  Occupancy;

    logic        b_redir_valid;
    logic [31:0] b_redir_pc;
    logic        b_ready;
    logic [31:0] b_rd_data = 32'h0;
    logic [31:0] b_rd_addr;
    logic        b_rd_en;
    logic        b_valid;
    logic [31:0] b_instr;
    logic [31:0] b_pcp4;
    logic [2:0]  b_occ;

    int total = 0;
    int bad   = 0;

    fetch_prefetch_unit #(.RESET_PC(32'h00000000), .QDEPTH(4)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ImemRdAddr   (ImemRdAddr),
        .ImemRdEn     (ImemRdEn),
        .ImemRdData   (ImemRdData),
        .RedirectValid(RedirectValid),
        .RedirectPC   (RedirectPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instruction  (Instruction),
        .PCPlus4      (PCPlus4),
        .Occupancy    (Occupancy)
    );

    fetch_prefetch_unit #(.RESET_PC(32'hFFFFFFF8), .QDEPTH(4)) dut_wrap (
        .Clk          (Clk),
        .Rst          (Rst),
        .ImemRdAddr   (b_rd_addr),
        .ImemRdEn     (b_rd_en),
        .ImemRdData   (b_rd_data),
        .RedirectValid(b_redir_valid),
        .RedirectPC   (b_redir_pc),
        .InstrValid   (b_valid),
        .InstrReady   (b_ready),
        .Instruction  (b_instr),
        .PCPlus4      (b_pcp4),
        .Occupancy    (b_occ)
    );

    // Instruction memory: each word is the bitwise inverse of its address.
    always @(posedge Clk) begin
        if (ImemRdEn) ImemRdData <= ~ImemRdAddr;
        if (b_rd_en)  b_rd_data  <= ~b_rd_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pcp4);
        chk({tag, "_valid"}, 32'(InstrValid), 32'd1);
        chk({tag, "_pcp4"}, PCPlus4, pcp4);
        chk({tag, "_instr"}, Instruction, ~(pcp4 - 32'd4));
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst           = 1'b1;
        RedirectValid = 1'b0;
        RedirectPC    = 32'h0;
        InstrReady    = 1'b1;
        b_redir_valid = 1'b0;
        b_redir_pc    = 32'h0;
        b_ready       = 1'b1;

        // reset state
        @(negedge Clk);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_occ", 32'(Occupancy), 32'd0);
        chk("rst_en", 32'(ImemRdEn), 32'd0);
        chk("rst_b_en", 32'(b_rd_en), 32'd0);
        next_cycle();
        Rst = 1'b0;

        // C1: first issue from RESET_PC
        @(negedge Clk);
        chk("c1_valid", 32'(InstrValid), 32'd0);
        chk("c1_en", 32'(ImemRdEn), 32'd1);
        chk("c1_addr", ImemRdAddr, 32'h0);
        chk("c1_b_addr", b_rd_addr, 32'hFFFFFFF8);
        next_cycle();
        // C2
        @(negedge Clk);
        chk("c2_valid", 32'(InstrValid), 32'd0);
        chk("c2_addr", ImemRdAddr, 32'h4);
        chk("c2_b_addr", b_rd_addr, 32'hFFFFFFFC);
        next_cycle();
        // C3: first head
        @(negedge Clk);
        chk_head("c3", 32'h4);
        chk("c3_b_addr", b_rd_addr, 32'h0);
        chk("c3_b_pcp4", b_pcp4, 32'hFFFFFFFC);
        chk("c3_b_instr", b_instr, 32'h00000007);
        next_cycle();
        @(negedge Clk);
        chk_head("c4", 32'h8);
        chk("c4_b_pcp4", b_pcp4, 32'h0);
        chk("c4_b_instr", b_instr, 32'h00000003);
        next_cycle();
        @(negedge Clk);
        chk_head("c5", 32'hC);
        chk("c5_b_pcp4", b_pcp4, 32'h4);
        chk("c5_b_instr", b_instr, 32'hFFFFFFFF);
        next_cycle();
        @(negedge Clk);
        chk_head("c6", 32'h10);
        chk("c6_occ", 32'(Occupancy), 32'd1);
        next_cycle();

        // Backpressure: ten stalled cycles, queue saturates
        InstrReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            chk_head("stall", 32'h14);
            if (i >= 2) chk("stall_en", 32'(ImemRdEn), 32'd0);
            if (i >= 3) chk("stall_occ", 32'(Occupancy), 32'd4);
            next_cycle();
        end
        InstrReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk_head("drain", 32'h14 + 32'(4 * i));
            if (i == 0) chk("drain_occ", 32'(Occupancy), 32'd4);
            next_cycle();
        end

        // Build up 2 queued + in flight, then 3 queued + in flight
        InstrReady = 1'b0;
        @(negedge Clk);
        chk("pre_redir_occ", 32'(Occupancy), 32'd2);
        chk("pre_redir_addr", ImemRdAddr, 32'h30);
        next_cycle();
        RedirectValid = 1'b1;
        RedirectPC    = 32'h00000043;
        @(negedge Clk);
        chk("redir_occ", 32'(Occupancy), 32'd3);
        chk("redir_valid", 32'(InstrValid), 32'd0);
        chk("redir_en", 32'(ImemRdEn), 32'd0);
        next_cycle();
        RedirectValid = 1'b0;
        InstrReady    = 1'b1;
        @(negedge Clk);
        chk("post_redir_occ", 32'(Occupancy), 32'd0);
        chk("post_redir_valid", 32'(InstrValid), 32'd0);
        chk("post_redir_en", 32'(ImemRdEn), 32'd1);
        chk("post_redir_addr", ImemRdAddr, 32'h40);
        next_cycle();
        @(negedge Clk);
        chk("post_redir2_valid", 32'(InstrValid), 32'd0);
        chk("post_redir2_addr", ImemRdAddr, 32'h44);
        next_cycle();
        @(negedge Clk);
        chk_head("redir_head", 32'h44);
        next_cycle();

        // Redirect with decode ready and a head pending, then back-to-back redirects
        RedirectValid = 1'b1;
        RedirectPC    = 32'h00000100;
        @(negedge Clk);
        chk("redir_pop_valid", 32'(InstrValid), 32'd0);
        chk("redir_pop_occ", 32'(Occupancy), 32'd1);
        chk("redir_pop_en", 32'(ImemRdEn), 32'd0);
        next_cycle();
        RedirectPC = 32'h00000200;
        @(negedge Clk);
        chk("b2b1_occ", 32'(Occupancy), 32'd0);
        chk("b2b1_en", 32'(ImemRdEn), 32'd0);
        next_cycle();
        RedirectPC = 32'h00000303;
        @(negedge Clk);
        chk("b2b2_en", 32'(ImemRdEn), 32'd0);
        chk("b2b2_valid", 32'(InstrValid), 32'd0);
        next_cycle();
        RedirectValid = 1'b0;
        InstrReady    = 1'b0;
        @(negedge Clk);
        chk("b2b_addr", ImemRdAddr, 32'h300);
        chk("b2b_en", 32'(ImemRdEn), 32'd1);
        next_cycle();
        @(negedge Clk);
        chk("b2b_next_addr", ImemRdAddr, 32'h304);
        chk("b2b_next_valid", 32'(InstrValid), 32'd0);
        next_cycle();
        @(negedge Clk);
        chk_head("b2b_head", 32'h304);
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge Clk);
        chk("full_occ", 32'(Occupancy), 32'd4);
        chk("full_en", 32'(ImemRdEn), 32'd0);
        chk_head("full_head", 32'h304);
        next_cycle();

        // One-cycle reset with a full queue
        Rst = 1'b1;
        @(negedge Clk);
        chk("midrst_en", 32'(ImemRdEn), 32'd0);
        next_cycle();
        Rst        = 1'b0;
        InstrReady = 1'b1;
        @(negedge Clk);
        chk("after_rst_occ", 32'(Occupancy), 32'd0);
        chk("after_rst_valid", 32'(InstrValid), 32'd0);
        chk("after_rst_addr", ImemRdAddr, 32'h0);
        next_cycle();
        @(negedge Clk);
        chk("after_rst2_valid", 32'(InstrValid), 32'd0);
        next_cycle();
        @(negedge Clk);
        chk_head("restart1", 32'h4);
        next_cycle();
        @(negedge Clk);
        chk_head("restart2", 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
